calc_frame_sequencer: RTL and testbench

Upstream command front-end for the 8-bit calculator core. It accepts a 3-byte frame (header, operand A, operand B) on a valid/ready byte stream, typically from a UART receiver. It then drives the calculator's load_opcode/load_a/load_b/execute strobes in order and captures the calculator's result and zero flag. The captured result is presented on a valid/ready output stream.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_frame_timer.sv | 51 +++++
 rtl/calc_frame_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_calc_frame_sequencer.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator frame sequencer.
//   state_t          : frame sequencer FSM states
//   opcode_t         : 3-bit calculator opcode
//   HDR_SYNC_DEFAULT : default value of the header sync field
//   HDR_* positions  : bit fields inside the header byte
// ----------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  typedef logic [2:0] opcode_t;

  localparam logic [2:0] HDR_SYNC_DEFAULT = 3'b101;

  // Header layout: [7:5] sync, [4:3] don't care, [2:0] opcode
  localparam int HDR_SYNC_MSB = 7;
  localparam int HDR_SYNC_LSB = 5;
  localparam int HDR_OP_MSB   = 2;
  localparam int HDR_OP_LSB   = 0;

  function automatic logic hdr_sync_ok(input logic [7:0] hdr, input logic [2:0] sync);
    return hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] == sync;
  endfunction

  function automatic opcode_t hdr_opcode(input logic [7:0] hdr);
    return hdr[HDR_OP_MSB:HDR_OP_LSB];
  endfunction

endpackage

// File: rtl/calc_frame_timer.sv
// ----------------------------------------------------------------------------
// calc_frame_timer
// Inter-byte timeout counter for the frame sequencer. Counts idle cycles while
// enabled and flags expiry when the count reaches TIMEOUT_CYCLES-1 on an
// enabled cycle. TIMEOUT_CYCLES = 0 disables expiry entirely.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : force the count back to zero (wins over enable_i)
//   enable_i : count this cycle (waiting for a byte, none accepted)
//   expire_o : combinational; terminal count reached on an enabled cycle
// ----------------------------------------------------------------------------
module calc_frame_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int  CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit  TIMER_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TERM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] count_q, count_d;
  logic          expire;

  assign expire   = TIMER_ON && enable_i && (count_q == TERM);
  assign expire_o = expire;

  // Expiry resets the count so the next frame starts from zero; with the
  // timer disabled the count is held so it can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i || expire) begin
      count_d = '0;
    end else if (enable_i && TIMER_ON) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/calc_frame_sequencer.sv
// ----------------------------------------------------------------------------
// calc_frame_sequencer
// Accepts a 3-byte frame (header, A, B) on a valid/ready byte stream, drives the
// calculator load/execute strobes in order, captures the result and zero flag
// and offers them on a valid/ready result stream.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_data_i/valid_i      : incoming frame bytes
//   in_ready_o             : byte accepted when in_valid_i && in_ready_o
//   calc_input_o           : operand bus to the calculator
//   calc_opcode_o          : opcode to the calculator
//   calc_load_opcode_o     : one-cycle opcode load strobe
//   calc_load_a_o/_b_o     : one-cycle operand load strobes
//   calc_execute_o         : one-cycle execute strobe
//   calc_result_i/zero_i   : calculator result register and zero flag
//   res_data_o/zero_o      : captured result
//   res_valid_o/ready_i    : result stream handshake
//   err_hdr_o              : one-cycle pulse, header sync rejected
//   err_timeout_o          : one-cycle pulse, frame aborted by timeout
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_HDR  | waiting for header byte
// S_A    | waiting for operand A (timeout active)
// S_B    | waiting for operand B (timeout active)
// S_EXEC | load_b on the bus; issue execute next cycle
// S_WAIT | execute on the bus, then capture calculator result
// S_OUT  | result held on res_* until res_ready_i
// ----------------------------------------------------------------------------
module calc_frame_sequencer
  import calc_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [2:0] HDR_SYNC       = HDR_SYNC_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] calc_input_o,
  output logic [2:0] calc_opcode_o,
  output logic       calc_load_opcode_o,
  output logic       calc_load_a_o,
  output logic       calc_load_b_o,
  output logic       calc_execute_o,
  input  logic [7:0] calc_result_i,
  input  logic       calc_zero_i,
  output logic [7:0] res_data_o,
  output logic       res_zero_o,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic       err_hdr_o,
  output logic       err_timeout_o
);

  state_t     state_q, state_d;

  logic [7:0] calc_input_q, calc_input_d;
  opcode_t    calc_opcode_q, calc_opcode_d;
  logic       load_opcode_q, load_opcode_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       execute_q, execute_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_zero_q, res_zero_d;
  logic       res_valid_q, res_valid_d;
  logic       err_hdr_q, err_hdr_d;
  logic       err_timeout_q, err_timeout_d;

  logic       accept;
  logic       hdr_ok;
  logic       in_frame;
  logic       expire;

  assign in_ready_o = (state_q == S_HDR) || (state_q == S_A) || (state_q == S_B);
  assign accept     = in_valid_i && in_ready_o;
  assign hdr_ok     = hdr_sync_ok(in_data_i, HDR_SYNC);
  assign in_frame   = (state_q == S_A) || (state_q == S_B);

  calc_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (accept || !in_frame),
    .enable_i(in_frame && !accept),
    .expire_o(expire)
  );

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_HDR;
      calc_input_q  <= '0;
      calc_opcode_q <= '0;
      load_opcode_q <= 1'b0;
      load_a_q      <= 1'b0;
      load_b_q      <= 1'b0;
      execute_q     <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      err_hdr_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      calc_input_q  <= calc_input_d;
      calc_opcode_q <= calc_opcode_d;
      load_opcode_q <= load_opcode_d;
      load_a_q      <= load_a_d;
      load_b_q      <= load_b_d;
      execute_q     <= execute_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_valid_q   <= res_valid_d;
      err_hdr_q     <= err_hdr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state logic. S_WAIT lasts until the execute strobe has been on the
  // bus for a full cycle, so the calculator's result register has updated
  // before it is captured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:  if (accept && hdr_ok) state_d = S_A;
      S_A: begin
        if (accept)      state_d = S_B;
        else if (expire) state_d = S_HDR;
      end
      S_B: begin
        if (accept)      state_d = S_EXEC;
        else if (expire) state_d = S_HDR;
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: if (!execute_q) state_d = S_OUT;
      S_OUT:  if (res_ready_i) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // Output next values: strobes default low, data buses hold their value.
  always_comb begin
    calc_input_d  = calc_input_q;
    calc_opcode_d = calc_opcode_q;
    load_opcode_d = 1'b0;
    load_a_d      = 1'b0;
    load_b_d      = 1'b0;
    execute_d     = 1'b0;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_valid_d   = res_valid_q;
    err_hdr_d     = 1'b0;
    err_timeout_d = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          if (hdr_ok) begin
            calc_opcode_d = hdr_opcode(in_data_i);
            load_opcode_d = 1'b1;
          end else begin
            err_hdr_d = 1'b1;
          end
        end
      end
      S_A: begin
        if (accept) begin
          calc_input_d = in_data_i;
          load_a_d     = 1'b1;
        end else if (expire) begin
          err_timeout_d = 1'b1;
        end
      end
      S_B: begin
        if (accept) begin
          calc_input_d = in_data_i;
          load_b_d     = 1'b1;
        end else if (expire) begin
          err_timeout_d = 1'b1;
        end
      end
      S_EXEC: execute_d = 1'b1;
      S_WAIT: begin
        if (!execute_q) begin
          res_data_d  = calc_result_i;
          res_zero_d  = calc_zero_i;
          res_valid_d = 1'b1;
        end
      end
      S_OUT: if (res_ready_i) res_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign calc_input_o       = calc_input_q;
  assign calc_opcode_o      = calc_opcode_q;
  assign calc_load_opcode_o = load_opcode_q;
  assign calc_load_a_o      = load_a_q;
  assign calc_load_b_o      = load_b_q;
  assign calc_execute_o     = execute_q;
  assign res_data_o         = res_data_q;
  assign res_zero_o         = res_zero_q;
  assign res_valid_o        = res_valid_q;
  assign err_hdr_o          = err_hdr_q;
  assign err_timeout_o      = err_timeout_q;

endmodule

// File: tb/tb_calc_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_frame_sequencer
// Two sequencer instances: g_dut[0] with TIMEOUT_CYCLES=8, g_dut[1] with the
// timeout disabled. `sel` routes the shared stimulus to one of them. Each has
// its own behavioural calculator. Expected results are queued when a frame is
// sent and popped when the sequencer presents its result.
// ----------------------------------------------------------------------------
module tb_calc_frame_sequencer;

  localparam int EV_LO = 0;
  localparam int EV_LA = 1;
  localparam int EV_LB = 2;
  localparam int EV_EX = 3;
  localparam int EV_EH = 4;
  localparam int EV_ET = 5;

  typedef struct {
    int code;
    int val;
    int cyc;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       res_ready;
  logic       sel;

  logic       vin   [2];
  logic       rrdy  [2];
  logic       rdy   [2];
  logic [7:0] cin   [2];
  logic [2:0] opc   [2];
  logic       lo    [2];
  logic       la    [2];
  logic       lb    [2];
  logic       ex    [2];
  logic [7:0] cres  [2];
  logic       czero [2];
  logic [7:0] rdata [2];
  logic       rzero [2];
  logic       rv    [2];
  logic       eh    [2];
  logic       et    [2];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  evq[$];
  exp_t sbq[$];

  function automatic logic [7:0] calc_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TO = (g == 0) ? 8 : 0;
    logic [2:0] m_op;
    logic [7:0] m_a, m_b, m_res;
    logic       m_z;

    assign vin[g]  = in_valid && (sel == (g != 0));
    assign rrdy[g] = res_ready && (sel == (g != 0));

    calc_frame_sequencer #(.TIMEOUT_CYCLES(TO)) u_dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .in_data_i         (in_data),
      .in_valid_i        (vin[g]),
      .in_ready_o        (rdy[g]),
      .calc_input_o      (cin[g]),
      .calc_opcode_o     (opc[g]),
      .calc_load_opcode_o(lo[g]),
      .calc_load_a_o     (la[g]),
      .calc_load_b_o     (lb[g]),
      .calc_execute_o    (ex[g]),
      .calc_result_i     (cres[g]),
      .calc_zero_i       (czero[g]),
      .res_data_o        (rdata[g]),
      .res_zero_o        (rzero[g]),
      .res_valid_o       (rv[g]),
      .res_ready_i       (rrdy[g]),
      .err_hdr_o         (eh[g]),
      .err_timeout_o     (et[g])
    );

    // Behavioural calculator: registers loaded by strobes, result on execute.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_op <= '0; m_a <= '0; m_b <= '0; m_res <= '0; m_z <= 1'b0;
      end else begin
        if (lo[g]) m_op <= opc[g];
        if (la[g]) m_a <= cin[g];
        if (lb[g]) m_b <= cin[g];
        if (ex[g]) begin
          m_res <= calc_fn(m_op, m_a, m_b);
          m_z   <= (calc_fn(m_op, m_a, m_b) == 8'h00);
        end
      end
    end
    assign cres[g]  = m_res;
    assign czero[g] = m_z;
  end

  logic       s_rdy, s_lo, s_la, s_lb, s_ex, s_rzero, s_rv, s_eh, s_et;
  logic [7:0] s_cin, s_rdata;
  logic [2:0] s_opc;
  assign s_rdy   = rdy[sel];
  assign s_cin   = cin[sel];
  assign s_opc   = opc[sel];
  assign s_lo    = lo[sel];
  assign s_la    = la[sel];
  assign s_lb    = lb[sel];
  assign s_ex    = ex[sel];
  assign s_rdata = rdata[sel];
  assign s_rzero = rzero[sel];
  assign s_rv    = rv[sel];
  assign s_eh    = eh[sel];
  assign s_et    = et[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/error monitor for the selected instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_lo) evq.push_back('{EV_LO, int'(s_opc), cyc});
      if (s_la) evq.push_back('{EV_LA, int'(s_cin), cyc});
      if (s_lb) evq.push_back('{EV_LB, int'(s_cin), cyc});
      if (s_ex) evq.push_back('{EV_EX, 0, cyc});
      if (s_eh) evq.push_back('{EV_EH, 0, cyc});
      if (s_et) evq.push_back('{EV_ET, 0, cyc});
    end
  end

  function automatic int count_ev(input int code, input int from);
    int n = 0;
    for (int i = from; i < evq.size(); i++) if (evq[i].code == code) n++;
    return n;
  endfunction

  function automatic int last_ev_cyc(input int code, input int from);
    int c = -1;
    for (int i = from; i < evq.size(); i++) if (evq[i].code == code) c = evq[i].cyc;
    return c;
  endfunction

  // Drive one byte starting at a negedge; returns the cycle index of the accept.
  task automatic send_byte(input logic [7:0] b, output int t_acc);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!s_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) begin
      n_chk++;
      $display("FAIL send_byte: in_ready stuck low, byte %h", b);
      in_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    t_acc    = cyc - 1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                            output int t_b);
    int t;
    send_byte(h, t);
    send_byte(a, t);
    send_byte(b, t_b);
  endtask

  task automatic wait_valid(output int rv_cyc);
    int n = 0;
    while (!s_rv && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_rv) begin
      n_chk++;
      $display("FAIL wait_valid: res_valid never rose");
      rv_cyc = -1;
    end else begin
      rv_cyc = cyc;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({s_cin, s_opc, s_lo, s_la, s_lb, s_ex, s_rdata, s_rzero, s_rv, s_eh, s_et} !== '0)
      $display("FAIL reset_outputs: got cin=%h opc=%h rdata=%h rv=%b", s_cin, s_opc, s_rdata, s_rv);
    else n_pass++;
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", s_rdy); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", s_rdy); else n_pass++;
  endtask

  task automatic test_basic();
    int   from, t_b, rv_c;
    int   ec[4];
    int   evl[4];
    exp_t e;
    ec  = '{EV_LO, EV_LA, EV_LB, EV_EX};
    evl = '{0, 5, 3, 0};
    from = evq.size();
    sbq.push_back('{8'h08, 1'b0});
    send_frame(8'hA0, 8'h05, 8'h03, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (rv_c !== t_b + 4) $display("FAIL basic_latency: res_valid at %0d want %0d", rv_c, t_b + 4);
    else n_pass++;
    n_chk++;
    if (s_rdata !== e.d) $display("FAIL basic_data: got %h want %h", s_rdata, e.d); else n_pass++;
    n_chk++;
    if (s_rzero !== e.z) $display("FAIL basic_zero: got %b want %b", s_rzero, e.z); else n_pass++;
    n_chk++;
    if (evq.size() - from !== 4) $display("FAIL basic_strobe_count: got %0d want 4", evq.size() - from);
    else n_pass++;
    if (evq.size() - from == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (evq[from+i].code !== ec[i] || evq[from+i].val !== evl[i] || evq[from+i].cyc !== t_b - 1 + i)
          $display("FAIL basic_strobe_%0d: got code=%0d val=%h cyc=%0d want code=%0d val=%h cyc=%0d",
                   i, evq[from+i].code, evq[from+i].val, evq[from+i].cyc, ec[i], evl[i], t_b - 1 + i);
        else n_pass++;
      end
    end
    handshake();
  endtask

  task automatic test_bad_hdr();
    int   from, t, t_b, rv_c;
    exp_t e;
    from = evq.size();
    send_byte(8'h45, t);
    repeat (3) @(negedge clk);
    n_chk++;
    if (evq.size() - from !== 1) $display("FAIL badhdr_events: got %0d want 1", evq.size() - from);
    else n_pass++;
    n_chk++;
    if (last_ev_cyc(EV_EH, from) !== t + 1)
      $display("FAIL badhdr_err_pulse: got cyc %0d want %0d", last_ev_cyc(EV_EH, from), t + 1);
    else n_pass++;
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL badhdr_in_ready: got %b want 1", s_rdy); else n_pass++;
    from = evq.size();
    sbq.push_back('{8'h00, 1'b1});
    send_frame(8'hA1, 8'h10, 8'h10, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (s_rdata !== e.d) $display("FAIL sub_data: got %h want %h", s_rdata, e.d); else n_pass++;
    n_chk++;
    if (s_rzero !== e.z) $display("FAIL sub_zero: got %b want %b", s_rzero, e.z); else n_pass++;
    n_chk++;
    if (count_ev(EV_EH, from) !== 0 || count_ev(EV_EX, from) !== 1)
      $display("FAIL sub_events: got eh=%0d ex=%0d want 0 1", count_ev(EV_EH, from), count_ev(EV_EX, from));
    else n_pass++;
    handshake();
  endtask

  task automatic test_timeout();
    int   from, t, t_a, t_b, n, rv_c;
    exp_t e;
    from = evq.size();
    send_byte(8'hA0, t);
    send_byte(8'h07, t_a);
    n = 0;
    while (count_ev(EV_ET, from) == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (last_ev_cyc(EV_ET, from) !== t_a + 9)
      $display("FAIL timeout_cycle: got %0d want %0d", last_ev_cyc(EV_ET, from), t_a + 9);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (count_ev(EV_ET, from) !== 1 || count_ev(EV_LB, from) !== 0 || count_ev(EV_EX, from) !== 0)
      $display("FAIL timeout_events: got et=%0d lb=%0d ex=%0d want 1 0 0",
               count_ev(EV_ET, from), count_ev(EV_LB, from), count_ev(EV_EX, from));
    else n_pass++;
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL timeout_in_ready: got %b want 1", s_rdy); else n_pass++;

    sbq.push_back('{8'h05, 1'b0});
    send_frame(8'hA0, 8'h02, 8'h03, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (s_rdata !== e.d) $display("FAIL after_timeout_data: got %h want %h", s_rdata, e.d); else n_pass++;
    handshake();

    // Byte on the 8th idle cycle must win over the abort.
    from = evq.size();
    sbq.push_back('{8'h10, 1'b0});
    send_byte(8'hA0, t);
    send_byte(8'h07, t_a);
    repeat (7) @(negedge clk);
    send_byte(8'h09, t_b);
    n_chk++;
    if (t_b !== t_a + 8) $display("FAIL rescue_accept_cycle: got %0d want %0d", t_b, t_a + 8); else n_pass++;
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (s_rdata !== e.d) $display("FAIL rescue_data: got %h want %h", s_rdata, e.d); else n_pass++;
    n_chk++;
    if (count_ev(EV_ET, from) !== 0) $display("FAIL rescue_no_abort: got %0d timeouts want 0", count_ev(EV_ET, from));
    else n_pass++;
    handshake();
  endtask

  task automatic test_backpressure();
    int   t_b, rv_c;
    exp_t e;
    sbq.push_back('{8'h0A, 1'b0});
    send_frame(8'hA0, 8'h05, 8'h05, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({s_rv, s_rdy, s_rdata, s_rzero} !== {1'b1, 1'b0, e.d, e.z})
        $display("FAIL hold_cycle_%0d: got rv=%b rdy=%b data=%h zero=%b want 1 0 %h %b",
                 i, s_rv, s_rdy, s_rdata, s_rzero, e.d, e.z);
      else n_pass++;
      @(negedge clk);
    end
    handshake();
    n_chk++;
    if ({s_rdy, s_rv} !== 2'b10) $display("FAIL release: got rdy=%b rv=%b want 1 0", s_rdy, s_rv);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   from, t, t_b, rv_c;
    exp_t e;
    from = evq.size();
    send_byte(8'hA3, t);
    send_byte(8'h05, t);
    n_chk++;
    if ({s_opc, s_cin} !== {3'd3, 8'h05}) $display("FAIL pre_reset_bus: got opc=%h cin=%h want 3 05", s_opc, s_cin);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_cin, s_opc, s_lo, s_la, s_lb, s_ex, s_rdata, s_rzero, s_rv, s_eh, s_et} !== '0)
      $display("FAIL async_reset_outputs: got cin=%h opc=%h", s_cin, s_opc);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (count_ev(EV_EX, from) !== 0) $display("FAIL reset_no_execute: got %0d want 0", count_ev(EV_EX, from));
    else n_pass++;
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL reset_mid_in_ready: got %b want 1", s_rdy); else n_pass++;
    sbq.push_back('{8'h03, 1'b0});
    send_frame(8'hA0, 8'h01, 8'h02, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (s_rdata !== e.d) $display("FAIL reset_mid_data: got %h want %h", s_rdata, e.d); else n_pass++;
    handshake();
  endtask

  task automatic test_no_timeout();
    int   from, t, t_b, rv_c;
    exp_t e;
    sel = 1'b1;
    @(negedge clk);
    from = evq.size();
    send_byte(8'hA0, t);
    repeat (1000) @(negedge clk);
    n_chk++;
    if (count_ev(EV_ET, from) !== 0) $display("FAIL notimeout_err: got %0d want 0", count_ev(EV_ET, from));
    else n_pass++;
    n_chk++;
    if (s_rdy !== 1'b1) $display("FAIL notimeout_in_ready: got %b want 1", s_rdy); else n_pass++;
    sbq.push_back('{8'h0A, 1'b0});
    send_byte(8'h04, t);
    send_byte(8'h06, t_b);
    wait_valid(rv_c);
    e = sbq.pop_front();
    n_chk++;
    if (rv_c !== t_b + 4) $display("FAIL notimeout_latency: got %0d want %0d", rv_c, t_b + 4); else n_pass++;
    n_chk++;
    if ({s_rdata, s_rzero} !== {e.d, e.z})
      $display("FAIL notimeout_result: got %h/%b want %h/%b", s_rdata, s_rzero, e.d, e.z);
    else n_pass++;
    handshake();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    sel       = 1'b0;
    test_reset();
    test_basic();
    test_bad_hdr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_no_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
